// File: rtl/cla_serial_adder.sv
// cla_serial_adder: wide adder built by reusing one 4-bit carry-lookahead
// slice, one nibble per clock, least significant nibble first.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:1] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is expanded directly from generate/propagate and cin, so no
  // carry ripples through the slice.
  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

  assign s    = p ^ {c[3], c[2], c[1], cin};
  assign cout = c[4];

endmodule

module cla_serial_adder #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IDX_W   = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           next_state;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_s;
  logic             nib_cout;
  logic             last;

  // The slice always sees the current nibble of the latched operands; the
  // raw a/b ports are never used once the addition has started.
  assign nib_a = a_reg[{idx, 2'b00} +: 4];
  assign nib_b = b_reg[{idx, 2'b00} +: 4];
  assign last  = (idx == IDX_W'(NIBBLES - 1));

  cla_4bit slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (nib_s),
    .cout (nib_cout)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state: abort beats completion in RUN; DONE always lasts one cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        if (abort)     next_state = IDLE;
        else if (last) next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are pure state decodes, so they are mutually exclusive.
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == RUN);
    done  = (state == DONE);
  end

  // Datapath: operand capture on accept, one nibble written per RUN edge, and
  // final flags computed from the top nibble's sign bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        RUN: begin
          if (abort) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
          end else begin
            sum[{idx, 2'b00} +: 4] <= nib_s;
            carry                  <= nib_cout;
            if (last) begin
              cout <= nib_cout;
              ovf  <= a_reg[W-1] ^ b_reg[W-1] ^ nib_s[3] ^ nib_cout;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb_cla_serial_adder: directed and random checks of the serial CLA adder.

module tb_cla_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] sa;
  logic [W-1:0] sb;
  logic         sc;
  logic [W:0]   ref_full;

  cla_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed overflow from the operand/result signs, independent of carries.
  function automatic logic refOvf(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic [W-1:0] s);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Runs one addition starting at the current negedge; checks the handshake
  // every cycle and the result in DONE and after returning to IDLE.
  // Operand inputs are scrambled while busy to show they are not resampled.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv);
    logic [W:0] exp_full;
    logic       exp_ovf;
    exp_full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    exp_ovf  = refOvf(av, bv, exp_full[W-1:0]);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    for (int k = 0; k < NIBBLES; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("run_flags", 32'({ready, busy, done}), 32'(3'b010));
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    end
    @(negedge clk);
    checkOutput("done_flags", 32'({ready, busy, done}), 32'(3'b001));
    checkOutput("done_result", 32'({cout, sum}), 32'(exp_full));
    @(negedge clk);
    checkOutput("idle_flags", 32'({ready, busy, done}), 32'(3'b100));
    checkOutput("hold_result", 32'({cout, sum}), 32'(exp_full));
    checkOutput("ovf", 32'(ovf), 32'(exp_ovf));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state.
    #12;
    checkOutput("reset_flags", 32'({ready, busy, done}), 32'(3'b100));
    checkOutput("reset_result", 32'({ovf, cout, sum}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_release_ready", 32'(ready), 32'(1));

    // Directed corner cases.
    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkOutput("ffff_plus_1", 32'({ovf, cout, sum}), 32'(18'h1_0000));
    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkOutput("pos_overflow", 32'({ovf, cout, sum}), 32'(18'h2_8000));
    applyStimulus(16'h8000, 16'h8000, 1'b1);
    checkOutput("neg_overflow", 32'({ovf, cout, sum}), 32'(18'h3_0001));

    // Abort together with start in IDLE: start wins.
    abort = 1'b1;
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    checkOutput("start_beats_abort", 32'(sum), 32'(16'h3333));

    // Back-to-back random additions.
    for (int i = 0; i < 80; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
    end

    // Start held high with operands changing every cycle: only the values
    // present at each idle edge are used, one addition per 6 cycles.
    for (int c = 0; c < 18; c++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'b1;
      checkOutput("exclusive", 32'($countones({ready, busy, done})), 32'(1));
      case (c % 6)
        0: begin
          sa = a; sb = b; sc = cin;
          checkOutput("held_idle", 32'({ready, busy, done}), 32'(3'b100));
        end
        5: begin
          ref_full = {1'b0, sa} + {1'b0, sb} + {{W{1'b0}}, sc};
          checkOutput("held_done", 32'({ready, busy, done}), 32'(3'b001));
          checkOutput("held_result", 32'({cout, sum}), 32'(ref_full));
          checkOutput("held_ovf", 32'(ovf), 32'(refOvf(sa, sb, ref_full[W-1:0])));
        end
        default: checkOutput("held_busy", 32'({ready, busy, done}), 32'(3'b010));
      endcase
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);

    // Abort during the second RUN cycle.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_result", 32'({ovf, cout, sum}), 32'(0));
    for (int k = 0; k < 3; k++) begin
      checkOutput("abort_no_done", 32'({ready, busy, done}), 32'(3'b100));
      @(negedge clk);
    end
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkOutput("after_abort", 32'(sum), 32'(16'h5555));

    // Asynchronous reset between edges in the middle of RUN.
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_flags", 32'({ready, busy, done}), 32'(3'b100));
    checkOutput("async_rst_result", 32'({ovf, cout, sum}), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    checkOutput("async_rst_ready", 32'(ready), 32'(1));
    applyStimulus(16'hA5A5, 16'h5A5B, 1'b0);
    checkOutput("after_rst", 32'({ovf, cout, sum}), 32'(18'h1_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
